// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the uP16 instruction-memory loader.
package imem_loader_pkg;

  localparam logic [7:0] HDR_DEFAULT = 8'hA5;
  localparam int         IDX_W       = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_PAY   = 3'd2,
    S_WRITE = 3'd3,
    S_CHECK = 3'd4
  } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write port of the loader.
interface imem_loader_if #(
  parameter int ISIZE = 18,
  parameter int ASIZE = 8
);

  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_ready;
  logic             imem_we;
  logic [ASIZE-1:0] imem_addr;
  logic [ISIZE-1:0] imem_wdata;

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/imem_loader_inst_assembler.sv
// Packs three MSB-first payload bytes into one instruction word.
module inst_assembler
  import imem_loader_pkg::*;
#(
  parameter int ISIZE = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic [7:0]       byte_in,
  output logic [ISIZE-1:0] word,
  output logic             word_full
);

  logic [ISIZE-1:0] sr;
  logic [IDX_W-1:0] idx;

  // Only ISIZE bits are kept: the upper bits of byte 0 fall off the top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr  <= '0;
      idx <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (shift_en) begin
      sr  <= ISIZE'({sr[15:0], byte_in});
      idx <= (idx == IDX_W'(2)) ? '0 : idx + 1'b1;
    end
  end

  assign word      = sr;
  assign word_full = shift_en && (idx == IDX_W'(2));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: frames HDR,LEN,3*LEN payload,CK into instruction-memory writes.
//   state   | meaning
//   IDLE    | discard bytes until HDR
//   LEN     | latch instruction count
//   PAY     | collect three bytes of one instruction
//   WRITE   | one-cycle memory write, stream stalled
//   CHECK   | compare CK with running XOR
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         ISIZE = 18,
  parameter int         ASIZE = 8,
  parameter logic [7:0] HDR   = HDR_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  imem_loader_if.slave     bus,
  output logic             core_rst,
  output logic             load_done,
  output logic             load_err,
  output logic [ASIZE-1:0] count
);

  state_t           state;
  logic [ASIZE-1:0] len;
  logic [7:0]       ck;
  logic             accept;
  logic [ASIZE-1:0] count_nxt;
  logic [ISIZE-1:0] asm_word;
  logic             asm_full;

  assign bus.byte_ready = (state != S_WRITE);
  assign accept         = bus.byte_valid && bus.byte_ready;
  assign count_nxt      = count + ASIZE'(1);

  inst_assembler #(.ISIZE(ISIZE)) u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (state == S_IDLE),
    .shift_en  (accept && (state == S_PAY)),
    .byte_in   (bus.byte_data),
    .word      (asm_word),
    .word_full (asm_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      len       <= '0;
      ck        <= '0;
      count     <= '0;
      core_rst  <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && (bus.byte_data == HDR)) begin
            count     <= '0;
            ck        <= '0;
            core_rst  <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            state     <= S_LEN;
          end
        end
        S_LEN: begin
          if (accept) begin
            len   <= ASIZE'(bus.byte_data);
            ck    <= ck ^ bus.byte_data;
            state <= (ASIZE'(bus.byte_data) == '0) ? S_CHECK : S_PAY;
          end
        end
        S_PAY: begin
          if (accept) begin
            ck <= ck ^ bus.byte_data;
            if (asm_full) state <= S_WRITE;
          end
        end
        S_WRITE: begin
          count <= count_nxt;
          state <= (count_nxt == len) ? S_CHECK : S_PAY;
        end
        S_CHECK: begin
          if (accept) begin
            if (bus.byte_data == ck) begin
              load_done <= 1'b1;
              core_rst  <= 1'b0;
            end else begin
              load_err  <= 1'b1;
            end
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Address is the pre-increment count, valid while in WRITE.
  assign bus.imem_we    = (state == S_WRITE);
  assign bus.imem_addr  = count;
  assign bus.imem_wdata = asm_word;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized frame stimulus against a byte-level reference model of the loader.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       core_rst, load_done, load_err;
  logic [7:0] count;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  typedef struct {
    logic [7:0]  a;
    logic [17:0] d;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  mon_e;
  logic prev_we = 1'b0;

  imem_loader_if #(.ISIZE(18), .ASIZE(8)) bus ();

  imem_loader #(.ISIZE(18), .ASIZE(8), .HDR(8'hA5)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .core_rst  (core_rst),
    .load_done (load_done),
    .load_err  (load_err),
    .count     (count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] word_of(input logic [7:0] b0, b1, b2);
    int unsigned w;
    w = (b0 % 4) * 65536 + b1 * 256 + b2;
    return w[17:0];
  endfunction

  // Every write must match the next expected (addr, data) in order.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.imem_we) begin
        chk("ready_in_we", {31'd0, bus.byte_ready}, 0);
        chk("we_single", {31'd0, prev_we}, 0);
        if (exp_q.size() == 0) begin
          chk("we_extra", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("we_addr", {24'd0, bus.imem_addr}, {24'd0, mon_e.a});
          chk("we_data", {14'd0, bus.imem_wdata}, {14'd0, mon_e.d});
        end
      end
      prev_we <= bus.imem_we;
    end
  end

  // Enter and leave at a falling edge; returns the cycle number of the transfer.
  task automatic send_byte(input logic [7:0] b, input int gap, output int edge_at);
    bit ok;
    ok = 1'b0;
    repeat (gap) begin
      bus.byte_valid = 1'b0;
      @(negedge clk);
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    for (int n = 0; n < 20 && !ok; n++) begin
      ok = bus.byte_ready;
      @(negedge clk);
    end
    if (!ok) chk("timeout", 0, 1);
    edge_at = cyc;
    bus.byte_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] pay[$], input bit bad, input bit bp, input bit timed);
    int         n, g, e0, e1, e;
    logic [7:0] ck;
    n  = pay.size() / 3;
    ck = n[7:0];
    foreach (pay[i]) ck ^= pay[i];
    if (bad) ck ^= 8'($urandom_range(1, 255));
    for (int i = 0; i < n; i++)
      exp_q.push_back('{a: i[7:0], d: word_of(pay[3*i], pay[3*i+1], pay[3*i+2])});
    g = bp ? $urandom_range(0, 3) : 0;
    send_byte(8'hA5, g, e0);
    chk("hdr_core_rst", {31'd0, core_rst}, 1);
    chk("hdr_done_clr", {31'd0, load_done}, 0);
    chk("hdr_err_clr", {31'd0, load_err}, 0);
    send_byte(n[7:0], bp ? $urandom_range(0, 3) : 0, e);
    foreach (pay[i]) send_byte(pay[i], bp ? $urandom_range(0, 3) : 0, e);
    send_byte(ck, bp ? $urandom_range(0, 3) : 0, e1);
    chk("done", {31'd0, load_done}, {31'd0, !bad});
    chk("err", {31'd0, load_err}, {31'd0, bad});
    chk("core_rst", {31'd0, core_rst}, {31'd0, bad});
    chk("count", {24'd0, count}, n);
    chk("we_missing", exp_q.size(), 0);
    if (timed) chk("latency", e1 - e0, 2 + 4 * n);
  endtask

  initial begin
    logic [7:0] pay[$];
    int         e;
    rst            = 1'b1;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_core_rst", {31'd0, core_rst}, 1);
    chk("rst_ready", {31'd0, bus.byte_ready}, 1);
    chk("rst_we", {31'd0, bus.imem_we}, 0);
    chk("rst_addr", {24'd0, bus.imem_addr}, 0);
    chk("rst_wdata", {14'd0, bus.imem_wdata}, 0);
    chk("rst_count", {24'd0, count}, 0);
    chk("rst_done", {31'd0, load_done}, 0);
    chk("rst_err", {31'd0, load_err}, 0);
    rst = 1'b0;
    @(negedge clk);

    send_byte(8'h00, 0, e);
    send_byte(8'h3C, 1, e);
    chk("idle_core_rst", {31'd0, core_rst}, 1);
    chk("idle_done", {31'd0, load_done}, 0);
    chk("idle_count", {24'd0, count}, 0);

    pay = '{8'h03, 8'h12, 8'h34, 8'h00, 8'hAB, 8'hCD};
    run_frame(pay, 1'b0, 1'b0, 1'b1);
    run_frame(pay, 1'b1, 1'b0, 1'b0);
    pay = '{};
    run_frame(pay, 1'b0, 1'b0, 1'b1);
    pay = '{8'hA5, 8'hA5, 8'hA5, 8'hFF, 8'hA5, 8'h00};
    run_frame(pay, 1'b0, 1'b1, 1'b0);

    for (int f = 0; f < 8; f++) begin
      int n;
      n   = $urandom_range(0, 6);
      pay = '{};
      for (int i = 0; i < 3 * n; i++) pay.push_back(8'($urandom));
      run_frame(pay, ($urandom % 3) == 0, f[0], !f[0]);
    end

    pay = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_q.push_back('{a: 8'd0, d: word_of(8'h11, 8'h22, 8'h33)});
    send_byte(8'hA5, 0, e);
    send_byte(8'h02, 0, e);
    foreach (pay[i]) send_byte(pay[i], 0, e);
    rst = 1'b1;
    #1;
    chk("midrst_core_rst", {31'd0, core_rst}, 1);
    chk("midrst_count", {24'd0, count}, 0);
    chk("midrst_ready", {31'd0, bus.byte_ready}, 1);
    chk("midrst_we", {31'd0, bus.imem_we}, 0);
    chk("midrst_missing", exp_q.size(), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pay = '{};
    for (int i = 0; i < 9; i++) pay.push_back(8'($urandom));
    run_frame(pay, 1'b0, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
